mic1_cbus_encoder: RTL and testbench

Serializing encoder for the MIC-1 register-select path, the inverse of the 4-to-16 select decoder. It accepts a multi-hot WIDTH-bit select mask, such as a C-bus write-enable field, and emits one binary register index per beat, lowest index first, over a valid/ready stream. Its purpose is to drive single-port register-file writes from a multi-target C-bus field.

---
 rtl/mic1_enc_pkg.sv | 16 +
 rtl/mic1_lsb_prio_enc.sv | 21 ++
 rtl/mic1_cbus_encoder.sv | 86 ++++++++
 tb/tb_mic1_cbus_encoder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mic1_enc_pkg.sv
// Shared types and constants for the MIC-1 C-bus select encoder.
package mic1_enc_pkg;

  localparam int unsigned MIC1_ENC_WIDTH = 16;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } enc_state_e;

  // Binary index width for a WIDTH-bit select mask.
  function automatic int unsigned idx_w(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/mic1_lsb_prio_enc.sv
// Lowest-set-bit priority encoder with an exactly-one-bit-set flag.
module mic1_lsb_prio_enc import mic1_enc_pkg::*; #(
  parameter  int unsigned WIDTH = MIC1_ENC_WIDTH,
  localparam int unsigned IDX_W = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             onehot
);

  // Scan from the top so the lowest set bit wins; an empty vector gives 0.
  always_comb begin
    idx = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign onehot = (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/mic1_cbus_encoder.sv
// Serializes a multi-hot C-bus select mask into ascending register indices.
// Optional MIC1_ENC_ZERO_FLAG_EN: zero masks emit one beat flagged by code_zero.
module mic1_cbus_encoder import mic1_enc_pkg::*; #(
  parameter  int unsigned WIDTH = MIC1_ENC_WIDTH,
  localparam int unsigned IDX_W = idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] mask_in,
  input  logic             mask_valid,
  output logic             mask_ready,
  output logic [IDX_W-1:0] code_out,
  output logic             code_valid,
  input  logic             code_ready,
  output logic             code_last,
`ifdef MIC1_ENC_ZERO_FLAG_EN
  output logic             code_zero,
`endif
  output logic             busy
);

  enc_state_e       state;
  logic [WIDTH-1:0] pending;
  logic [IDX_W-1:0] lsb_idx;
  logic             lsb_onehot;
`ifdef MIC1_ENC_ZERO_FLAG_EN
  logic             zero_r;
`endif

  mic1_lsb_prio_enc #(.WIDTH(WIDTH)) u_prio (
    .vec    (pending),
    .idx    (lsb_idx),
    .onehot (lsb_onehot)
  );

  // FSM and pending register; each handshaken beat retires the lowest set bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
`ifdef MIC1_ENC_ZERO_FLAG_EN
      zero_r  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (mask_valid) begin
            if (mask_in != '0) begin
              pending <= mask_in;
              state   <= EMIT;
            end
`ifdef MIC1_ENC_ZERO_FLAG_EN
            else begin
              zero_r <= 1'b1;
              state  <= EMIT;
            end
`endif
          end
        end
        EMIT: begin
          if (code_ready) begin
            pending <= pending & (pending - WIDTH'(1));
`ifdef MIC1_ENC_ZERO_FLAG_EN
            zero_r  <= 1'b0;
`endif
            if (code_last) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode state and pending only; pending is empty outside EMIT.
  assign mask_ready = (state == IDLE);
  assign code_valid = (state == EMIT);
  assign busy       = (state == EMIT);
  assign code_out   = lsb_idx;
`ifdef MIC1_ENC_ZERO_FLAG_EN
  assign code_last  = (state == EMIT) && (lsb_onehot || zero_r);
  assign code_zero  = zero_r;
`else
  assign code_last  = (state == EMIT) && lsb_onehot;
`endif

endmodule

// File: tb/tb_mic1_cbus_encoder.sv
// Self-checking bench for mic1_cbus_encoder: vector table, scoreboard, corner sequences.
module tb_mic1_cbus_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mask_in;
  logic        mask_valid;
  logic        mask_ready;
  logic [3:0]  code_out;
  logic        code_valid;
  logic        code_ready;
  logic        code_last;
  logic        busy;
`ifdef MIC1_ENC_ZERO_FLAG_EN
  logic        code_zero;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] code;
    logic       last;
    logic       zero;
  } exp_t;

  typedef struct {
    logic [15:0] mask;
    int          beats;
    logic [3:0]  final_code;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[8];

  mic1_cbus_encoder #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mask_in    (mask_in),
    .mask_valid (mask_valid),
    .mask_ready (mask_ready),
    .code_out   (code_out),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .code_last  (code_last),
`ifdef MIC1_ENC_ZERO_FLAG_EN
    .code_zero  (code_zero),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: ascending set bits, last flag on the highest one.
  task automatic push_model(input logic [15:0] m);
    exp_t e;
    if (m == 16'h0000) begin
`ifdef MIC1_ENC_ZERO_FLAG_EN
      e.code = 4'd0; e.last = 1'b1; e.zero = 1'b1;
      exp_q.push_back(e);
`endif
      return;
    end
    for (int i = 0; i < 16; i++) begin
      if (m[i]) begin
        e.code = 4'(i);
        e.last = ((m >> (i + 1)) == 16'h0000);
        e.zero = 1'b0;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic check_beat(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, " unexpected beat"}, 32'(code_valid), 32'd0);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, " code"}, 32'(code_out), 32'(e.code));
    chk({tag, " last"}, 32'(code_last), 32'(e.last));
`ifdef MIC1_ENC_ZERO_FLAG_EN
    chk({tag, " zero"}, 32'(code_zero), 32'(e.zero));
`endif
  endtask

  // Called at a negedge with the DUT idle and code_ready high.
  task automatic run_vec(input vec_t v, input int idx);
    int         beats;
    logic [3:0] last_code;
    string      tag;
    tag = $sformatf("vec%0d", idx);
    chk({tag, " idle mask_ready"}, 32'(mask_ready), 32'd1);
    mask_in    = v.mask;
    mask_valid = 1'b1;
    push_model(v.mask);
    @(posedge clk);
    #1;
    mask_valid = 1'b0;
    mask_in    = ~v.mask;
    @(negedge clk);
    beats     = 0;
    last_code = 4'd0;
    while (code_valid && beats < 20) begin
      check_beat(tag);
      last_code = code_out;
      beats++;
      @(negedge clk);
    end
    chk({tag, " beat count"}, 32'(beats), 32'(v.beats));
    if (v.beats > 0) chk({tag, " final code"}, 32'(last_code), 32'(v.final_code));
    chk({tag, " queue drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    chk({tag, " turnaround mask_ready"}, 32'(mask_ready), 32'd1);
    chk({tag, " turnaround busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{16'h8421, 4, 4'd15};
    vecs[1] = '{16'h8000, 1, 4'd15};
    vecs[2] = '{16'h0001, 1, 4'd0};
    vecs[3] = '{16'h0006, 2, 4'd2};
    vecs[4] = '{16'hA5A5, 8, 4'd15};
    vecs[5] = '{16'hFFFF, 16, 4'd15};
`ifdef MIC1_ENC_ZERO_FLAG_EN
    vecs[6] = '{16'h0000, 1, 4'd0};
`else
    vecs[6] = '{16'h0000, 0, 4'd0};
`endif
    vecs[7] = '{16'h4002, 2, 4'd14};

    // Reset held with a full mask offered.
    rst_n      = 1'b0;
    mask_in    = 16'hFFFF;
    mask_valid = 1'b1;
    code_ready = 1'b1;
    #3;
    chk("reset mask_ready", 32'(mask_ready), 32'd1);
    chk("reset code_valid", 32'(code_valid), 32'd0);
    chk("reset code_out", 32'(code_out), 32'd0);
    chk("reset code_last", 32'(code_last), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
`ifdef MIC1_ENC_ZERO_FLAG_EN
    chk("reset code_zero", 32'(code_zero), 32'd0);
`endif
    @(negedge clk);
    mask_valid = 1'b0;
    rst_n      = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("post-reset no code", 32'(code_valid), 32'd0);
    end

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Backpressure, with a second mask held pending during EMIT.
    code_ready = 1'b0;
    mask_in    = 16'h0006;
    mask_valid = 1'b1;
    @(posedge clk);
    #1;
    mask_in = 16'h0010;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp valid", 32'(code_valid), 32'd1);
      chk("bp hold code", 32'(code_out), 32'd1);
      chk("bp hold last", 32'(code_last), 32'd0);
      chk("bp mask_ready", 32'(mask_ready), 32'd0);
    end
    code_ready = 1'b1;
    @(negedge clk);
    chk("bp beat2 code", 32'(code_out), 32'd2);
    chk("bp beat2 last", 32'(code_last), 32'd1);
    @(negedge clk);
    chk("bp turnaround ready", 32'(mask_ready), 32'd1);
    chk("bp turnaround idle", 32'(code_valid), 32'd0);
    @(negedge clk);
    mask_valid = 1'b0;
    chk("held mask valid", 32'(code_valid), 32'd1);
    chk("held mask code", 32'(code_out), 32'd4);
    chk("held mask last", 32'(code_last), 32'd1);
    @(negedge clk);
    chk("held mask done", 32'(code_valid), 32'd0);

    // Reset in the middle of a full mask.
    mask_in    = 16'hFFFF;
    mask_valid = 1'b1;
    @(posedge clk);
    #1;
    mask_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("midrst code%0d", c), 32'(code_out), 32'(c));
    end
    #2;
    rst_n      = 1'b0;
    mask_valid = 1'b1;
    #1;
    chk("midrst async valid", 32'(code_valid), 32'd0);
    chk("midrst async ready", 32'(mask_ready), 32'd1);
    chk("midrst async busy", 32'(busy), 32'd0);
    @(negedge clk);
    mask_valid = 1'b0;
    rst_n      = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("midrst no code", 32'(code_valid), 32'd0);
      chk("midrst busy", 32'(busy), 32'd0);
      chk("midrst ready", 32'(mask_ready), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
